ysyx_25020077_sram: RTL
=======================

YSYX_25020077_SRAM -- requirements
Module: ysyx_25020077_sram

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, legal range 1..15: cycles spent in WAIT per transaction.
REQ-003 Parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  one clock; reset is asynchronous and active-low (0 = reset asserted).
REQ-006 req_valid  in  1  initiator presents a request.
REQ-007 req_ready  out  1  responder can accept a request.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wen  in  1  1 = write, 0 = read.
REQ-010 req_wdata  in  32  write data.
REQ-011 req_wmask  in  4  byte strobes; bit i enables byte i.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  initiator accepts response.
REQ-014 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-015 rsp_err  out  1  access fault.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT and RESP, with one transaction outstanding at most.
REQ-017 req_ready SHALL be 1 only when state is IDLE and reset is deasserted.
REQ-018 Accept: req_valid&&req_ready at an edge; addr/wen/wdata/wmask latched; counter loaded with LATENCY-1; IDLE->WAIT.
REQ-019 WAIT: counter decrements each edge; at the edge where counter==0, access performed, WAIT->RESP.
REQ-020 rsp_valid SHALL first be high exactly LATENCY edges after the accepting edge.
REQ-021 RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready; at that edge RESP->IDLE, rsp_valid=0.
REQ-022 Earliest next accept: the edge after response handshake; minimum period LATENCY+2 cycles.
REQ-023 Index = (addr-BASE_ADDR)>>2 (32-bit unsigned subtraction, wrap allowed).
REQ-024 Error: addr[1:0]!=0 or addr<BASE_ADDR or index>=DEPTH_WORDS -> rsp_err=1, rsp_rdata=0, no storage change.
REQ-025 Write: only bytes with wmask bit set updated; rsp_rdata=0, rsp_err=0; wmask=0 is a legal no-op write.
REQ-026 Read: rsp_rdata = stored word at access edge; a read after a completed write to the same word returns the new data.
REQ-027 req_* changes while not in IDLE SHALL be ignored.

Reset
REQ-028 On reset assertion: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 (all asynchronous).
REQ-029 On reset deassertion: req_ready=1 in the following cycle.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 Reset during WAIT aborts the transaction, and its write SHALL NOT occur; reset during RESP drops the response.

Structure
REQ-032 A shared package ysyx_25020077_pkg SHALL hold the FSM state enum, default BASE_ADDR, default LATENCY and default DEPTH_WORDS.
REQ-033 The storage array SHALL be a sub-module ysyx_25020077_sram_array: synchronous byte-masked write, read sampled on the access edge.
REQ-034 The top SHALL contain the FSM, counter, address decode and response registers.

Verification
REQ-035 Reset deassert, LATENCY=2, write 0x8000_0010 data 0xDEADBEEF mask 4'hF, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_err=0; then read 0x8000_0010 -> rsp_rdata=0xDEADBEEF.
REQ-036 Preload 0x11223344 at 0x8000_0000, write 0xAABBCCDD mask 4'b0101 -> subsequent read returns 0x11BB33DD.
REQ-037 Reads at 0x8000_0002, 0x7FFF_FFFC and BASE+4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0; a write to the same addresses leaves the array unchanged.
REQ-038 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable throughout, req_ready=0; handshake on 6th cycle -> IDLE next cycle.
REQ-039 Assert reset one cycle after accepting a write to 0x8000_0020 (0x12345678) -> rsp_valid=0 immediately; after release, read 0x8000_0020 returns the prior contents.
REQ-040 Back-to-back requests with req_valid held high, rsp_ready=1, LATENCY=1 -> accepts spaced exactly 3 cycles, no request lost or duplicated.

Source files
------------

// File: rtl/ysyx_25020077_sram_pkg.sv
// Shared definitions for the simulated SRAM responder: FSM states,
// default geometry/timing and a small byte-strobe helper.
package ysyx_25020077_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } sram_state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h8000_0000;
    localparam int unsigned DEFAULT_LATENCY     = 2;
    localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] byteMaskToBits(input logic [3:0] mask);
        logic [31:0] bits;
        bits = '0;
        for (int b = 0; b < 4; b++) begin
            bits[b*8 +: 8] = {8{mask[b]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/ysyx_25020077_sram_if.sv
// Request/response bus between an initiator and the SRAM responder.
interface ysyx_25020077_sram_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ysyx_25020077_sram_array.sv
// Word-organised storage with a synchronous byte-masked write port and a
// read register that captures the addressed word on the access edge.
// The storage itself is never reset; only the read register is.
module ysyx_25020077_sram_array
    import ysyx_25020077_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wmask_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] bitMask;

    assign bitMask = byteMaskToBits(wmask_i);

    // Merge the enabled bytes of the write data into the addressed word.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[idx_i] <= (mem_q[idx_i] & ~bitMask) | (wdata_i & bitMask);
        end
    end

    // Capture the addressed word when a read is performed; hold otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_25020077_sram.sv
// Single-outstanding SRAM responder: accepts one request, waits LATENCY
// cycles, performs the access (or flags a fault) and holds the response
// until the initiator takes it.
module ysyx_25020077_sram
    import ysyx_25020077_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEFAULT_LATENCY,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                  clock,
    input  logic                  reset,
    ysyx_25020077_sram_if.slave   bus
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

    sram_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        rspErr_q, rspErr_d;
    logic        rdOk_q, rdOk_d;

    logic        accessEn;
    logic        fault;
    logic [31:0] offset;
    logic [IDX_W-1:0] idx;
    logic        arrayWe;
    logic        arrayRe;
    logic [31:0] arrayRdata;

    // Decode the latched address: word index relative to the base, plus the
    // misaligned / below-base / past-end fault.  The range test is done on the
    // byte offset so a wrapped subtraction still lands outside the span.
    assign offset = addr_q - BASE_ADDR;
    assign idx    = offset[IDX_W+1:2];
    assign fault  = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) || (offset >= SPAN_BYTES);

    assign arrayWe = accessEn && wen_q && !fault;
    assign arrayRe = accessEn && !wen_q && !fault;

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        rspErr_d = rspErr_q;
        rdOk_d   = rdOk_q;
        accessEn = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wen_d   = bus.req_wen;
                    wdata_d = bus.req_wdata;
                    wmask_d = bus.req_wmask;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    accessEn = 1'b1;
                    rspErr_d = fault;
                    rdOk_d   = !fault && !wen_q;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rspErr_d = 1'b0;
                    rdOk_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and response registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rspErr_q <= 1'b0;
            rdOk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            rspErr_q <= rspErr_d;
            rdOk_q   <= rdOk_d;
        end
    end

    ysyx_25020077_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .we_i    (arrayWe),
        .re_i    (arrayRe),
        .idx_i   (idx),
        .wdata_i (wdata_q),
        .wmask_i (wmask_q),
        .rdata_o (arrayRdata)
    );

    assign bus.req_ready = (state_q == ST_IDLE) && reset;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdOk_q ? arrayRdata : 32'h0;
    assign bus.rsp_err   = rspErr_q;

endmodule
